// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Hits answer one cycle after acceptance; misses refill a single word and bypass it to the CPU.
module icache_direct_mapped #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);

    localparam int LINES = 2 ** INDEX_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0] valid_bits;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [31:2]            miss_addr;
    logic [31:0]            hit_data;
    logic                   hit_pending;
    logic [INDEX_WIDTH-1:0] cpu_index;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic [TAG_W-1:0]       cpu_tag;
    logic [TAG_W-1:0]       miss_tag;
    logic                   hit;
    logic                   accept;
    logic                   refill_done;
    logic                   refill_req;
    logic                   unused_inputs;

    assign unused_inputs = ^{cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

    assign cpu_index  = cpu_inst_addr[INDEX_WIDTH+1:2];
    assign cpu_tag    = cpu_inst_addr[31:INDEX_WIDTH+2];
    assign miss_index = miss_addr[INDEX_WIDTH+1:2];
    assign miss_tag   = miss_addr[31:INDEX_WIDTH+2];
    assign hit        = valid_bits[cpu_index] && (tag_mem[cpu_index] == cpu_tag);

    // Acceptance is gated by resetn so the handshake stays low while reset is held.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        refill_done = 1'b0;
        refill_req  = 1'b0;
        case (state)
            IDLE: begin
                accept = resetn && cpu_inst_req && !cpu_inst_wr;
                if (accept && !hit) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                refill_req = 1'b1;
                if (cache_inst_addr_ok) begin
                    if (cache_inst_data_ok) begin
                        refill_done = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cache_inst_data_ok) begin
                    refill_done = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            valid_bits  <= '0;
            miss_addr   <= '0;
            hit_pending <= 1'b0;
            hit_data    <= '0;
        end else begin
            state       <= state_next;
            hit_pending <= accept && hit;
            if (accept) begin
                miss_addr <= cpu_inst_addr[31:2];
                if (hit) begin
                    hit_data <= data_mem[cpu_index];
                end
            end
            if (refill_done) begin
                valid_bits[miss_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= cache_inst_rdata;
        end
    end

    assign cpu_inst_addr_ok = accept;
    assign cpu_inst_data_ok = hit_pending || refill_done;
    assign cpu_inst_rdata   = refill_done ? cache_inst_rdata : hit_data;

    assign cache_inst_req   = refill_req;
    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = 2'b10;
    assign cache_inst_addr  = {miss_addr, 2'b00};
    assign cache_inst_wdata = '0;

    a_no_write_request : assert property (
        @(posedge clk) disable iff (!resetn)
        !(state == IDLE && cpu_inst_req && cpu_inst_wr)
    );

endmodule
